stage2: RTL and testbench
=========================

Name: stage2

Overview:
- Sequential oral-exam stage directly upstream of stage3.
- Runs a fixed-length question session, one answer per question, and scores each answer against a key. One lucky guess per session is permitted.
- Produces `pass2` and `bonus2[1:0]`, which feed stage3's `pass2`/`bonus2` inputs unchanged.
- Results are held stable from `done` until the next accepted `start`.

Parameters:
- NUM_Q, 8: questions per session (1..15).
- PASS_TH, 5: minimum score for `pass2`=1 (0..NUM_Q).
- STREAK_LEN, 3: consecutive correct answers that earn one bonus point (>=1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  session start request; sampled only in IDLE.
- ans_valid  input  1  an answer is presented on `ans`.
- ans  input  3  candidate answer.
- key  input  3  correct answer, sampled together with `ans`.
- luck2  input  3  luck mask, sampled together with `ans`.
- ans_ready  output  1  block accepts an answer this cycle.
- busy  output  1  session in progress (state is not IDLE).
- done  output  1  one-cycle pulse marking that the results are valid.
- score  output  4  running count of correct answers.
- pass2  output  1  session passed; goes to stage3.
- bonus2  output  2  bonus points, saturating at 3; goes to stage3.

Behaviour:
- Reset: when `rst`=1 at a rising edge, the FSM goes to IDLE. All counters, the `lucky_used` flag and every output go to 0. Reset applies in any state, including mid-session, and has priority over every other input.
- The FSM has four states: IDLE, ASK, JUDGE, DONE. Outputs are registered except `ans_ready` (= state==ASK) and `busy` (= state!=IDLE).
- IDLE:
  - `start`=1 clears `q_cnt`, `score`, `streak`, `bonus_cnt`, `lucky_used`, `pass2` and `bonus2`, then moves to ASK.
  - `ans_valid` is ignored.
- ASK:
  - When `ans_valid`=1 (handshake `ans_valid`&`ans_ready`), capture `ans`, `key` and `luck2`, then move to JUDGE.
  - Otherwise stay in ASK; waiting has no limit.
  - `start` is ignored in every state except IDLE.
- JUDGE (exactly 1 cycle; `ans_ready`=0, so back-to-back answers carry a 1-cycle bubble). Use the captured values:
  - **Hit:** `ans`==`key`.
  - **Lucky:** `ans`!=`key`, (`ans` XOR `luck2`)==`key`, and `lucky_used`=0. This sets `lucky_used`=1 and counts as a hit.
  - **On a hit:** `score`+=1 and `streak`+=1. If `streak` reaches STREAK_LEN, then `streak`=0 and `bonus_cnt`=min(`bonus_cnt`+1, 3).
  - **On a miss:** `streak`=0.
  - Always `q_cnt`+=1. If the new `q_cnt`==NUM_Q, go to DONE; else go to ASK.
- Result registers: on the same JUDGE->DONE edge, `pass2` <= (final `score` >= PASS_TH) and `bonus2` <= final `bonus_cnt`. The final `score` includes the last answer.
- DONE: `done`=1 for exactly this one cycle, then the FSM goes to IDLE.
- Holding results: `pass2`, `bonus2` and `score` hold their values in IDLE until the next accepted `start` clears them.
- Latency: with `ans_valid` held high, `done` is asserted 2*NUM_Q+1 cycles after the cycle in which `start` was sampled. With NUM_Q=8 this is 17 cycles.
- Widths and arithmetic:
  - `score` is 4-bit, and NUM_Q<=15 guarantees it never wraps.
  - `bonus_cnt` saturates at 3 and never wraps.
  - `streak` needs ceil(log2(STREAK_LEN+1)) bits.
- Boundary cases:
  - NUM_Q=1: ASK, JUDGE, DONE with no further ASK.
  - PASS_TH=0: `pass2`=1 always at `done`.
  - A lucky case with `luck2`=0 cannot occur, because it reduces to a hit.
  - A second lucky-eligible miss in the same session counts as a miss.

Test Plan:
1. Default params, start, then 8 answers with `ans`==`key` and `ans_valid` held high -> `done` at cycle 17; `score`=8, `bonus2`=2 (streak rewards after answers 3 and 6), `pass2`=1.
2. Pattern H,H,M,H,H,M,H,M (H = hit, M = miss) -> `score`=5, `pass2`=1, `bonus2`=0. Flip the last H to M -> `score`=4, `pass2`=0.
3. Lucky rule: Q1 `ans`=3, `key`=5, `luck2`=6 (3^6=5) -> counted as hit. Q2 with the same values -> miss. Remaining 6 answers all hits -> `score`=7, `bonus2`=2 (streak rewards after answers 5 and 8).
4. Saturation: NUM_Q=12 with all hits -> `bonus2`=3 (the 4th streak is saturated), `score`=12, `pass2`=1.
5. Handshake:
   - Random `ans_valid` gaps -> exactly NUM_Q answers are consumed, and `ans_ready`=0 in every JUDGE cycle.
   - `start` pulsed mid-session -> ignored.
   - After `done`, `pass2`/`bonus2` stay held for 10 idle cycles, then clear on the next `start`.
6. `rst`=1 after the 4th answer -> next cycle the FSM is in IDLE with all outputs 0. A new start then runs a full 8-question session with the correct results.

Source files
------------

// File: rtl/stage2.sv
// Oral-exam stage: scores a fixed-length answer session against a key, with one
// lucky guess per session, and hands pass2/bonus2 to stage3.
module stage2 #(
   parameter int unsigned NUM_Q      = 8,
   parameter int unsigned PASS_TH    = 5,
   parameter int unsigned STREAK_LEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       ans_valid,
   input  logic [2:0] ans,
   input  logic [2:0] key,
   input  logic [2:0] luck2,
   output logic       ans_ready,
   output logic       busy,
   output logic       done,
   output logic [3:0] score,
   output logic       pass2,
   output logic [1:0] bonus2
);

   localparam int unsigned SW = $clog2(STREAK_LEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_ASK, S_JUDGE, S_DONE} state_t;

   state_t        r_state;
   logic [3:0]    r_q_cnt;
   logic [3:0]    r_score;
   logic [SW-1:0] r_streak;
   logic [1:0]    r_bonus;
   logic          r_lucky_used;
   logic [2:0]    r_ans, r_key, r_luck;
   logic          r_done;
   logic          r_pass2;
   logic [1:0]    r_bonus2;

   logic          w_exact, w_lucky, w_hit, w_last;
   logic [3:0]    w_q_nxt, w_score_nxt;
   logic [SW-1:0] w_streak_inc, w_streak_nxt;
   logic [1:0]    w_bonus_nxt;

   // The lucky guess only applies to a wrong answer, and only once per session.
   assign w_exact      = (r_ans == r_key);
   assign w_lucky      = !w_exact && ((r_ans ^ r_luck) == r_key) && !r_lucky_used;
   assign w_hit        = w_exact || w_lucky;
   assign w_q_nxt      = r_q_cnt + 4'd1;
   assign w_last       = (w_q_nxt == 4'(NUM_Q));
   assign w_streak_inc = r_streak + SW'(1);

   always_comb begin
      w_score_nxt  = r_score;
      w_streak_nxt = '0;
      w_bonus_nxt  = r_bonus;
      if (w_hit) begin
         w_score_nxt = r_score + 4'd1;
         if (w_streak_inc == SW'(STREAK_LEN)) begin
            w_streak_nxt = '0;
            if (r_bonus != 2'd3) w_bonus_nxt = r_bonus + 2'd1;
         end else begin
            w_streak_nxt = w_streak_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_q_cnt      <= '0;
         r_score      <= '0;
         r_streak     <= '0;
         r_bonus      <= '0;
         r_lucky_used <= 1'b0;
         r_ans        <= '0;
         r_key        <= '0;
         r_luck       <= '0;
         r_done       <= 1'b0;
         r_pass2      <= 1'b0;
         r_bonus2     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_q_cnt      <= '0;
                  r_score      <= '0;
                  r_streak     <= '0;
                  r_bonus      <= '0;
                  r_lucky_used <= 1'b0;
                  r_pass2      <= 1'b0;
                  r_bonus2     <= '0;
                  r_state      <= S_ASK;
               end
            end
            S_ASK: begin
               if (ans_valid) begin
                  r_ans   <= ans;
                  r_key   <= key;
                  r_luck  <= luck2;
                  r_state <= S_JUDGE;
               end
            end
            S_JUDGE: begin
               r_q_cnt  <= w_q_nxt;
               r_score  <= w_score_nxt;
               r_streak <= w_streak_nxt;
               r_bonus  <= w_bonus_nxt;
               if (w_lucky) r_lucky_used <= 1'b1;
               // Results use the post-update score so the last answer counts.
               if (w_last) begin
                  r_state  <= S_DONE;
                  r_done   <= 1'b1;
                  r_pass2  <= (w_score_nxt >= 4'(PASS_TH));
                  r_bonus2 <= w_bonus_nxt;
               end else begin
                  r_state  <= S_ASK;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ans_ready = (r_state == S_ASK);
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign score     = r_score;
   assign pass2     = r_pass2;
   assign bonus2    = r_bonus2;

endmodule

// File: tb/tb_stage2.sv
// Directed bench for stage2: expected session results are queued when a session
// is driven and checked against the outputs when done pulses.
module tb_stage2;

   logic       clk = 1'b0;
   logic       rst, start, start12, ans_valid;
   logic [2:0] ans, key, luck2;

   logic       rdy8, busy8, done8, pass8;
   logic [3:0] score8;
   logic [1:0] bonus8;
   logic       rdy12, busy12, done12, pass12;
   logic [3:0] score12;
   logic [1:0] bonus12;

   always #5 clk = ~clk;

   stage2 dut (
      .clk(clk), .rst(rst), .start(start), .ans_valid(ans_valid),
      .ans(ans), .key(key), .luck2(luck2),
      .ans_ready(rdy8), .busy(busy8), .done(done8),
      .score(score8), .pass2(pass8), .bonus2(bonus8)
   );

   stage2 #(.NUM_Q(12), .PASS_TH(5), .STREAK_LEN(3)) dut12 (
      .clk(clk), .rst(rst), .start(start12), .ans_valid(ans_valid),
      .ans(ans), .key(key), .luck2(luck2),
      .ans_ready(rdy12), .busy(busy12), .done(done12),
      .score(score12), .pass2(pass12), .bonus2(bonus12)
   );

   logic       sel12;
   logic       s_ready, s_busy, s_done, s_pass2;
   logic [3:0] s_score;
   logic [1:0] s_bonus2;
   assign s_ready  = sel12 ? rdy12   : rdy8;
   assign s_busy   = sel12 ? busy12  : busy8;
   assign s_done   = sel12 ? done12  : done8;
   assign s_pass2  = sel12 ? pass12  : pass8;
   assign s_score  = sel12 ? score12 : score8;
   assign s_bonus2 = sel12 ? bonus12 : bonus8;

   typedef struct {
      logic [3:0] score;
      logic       pass2;
      logic [1:0] bonus;
   } exp_t;

   exp_t       sb[$];
   exp_t       last_e;
   logic [2:0] qa[16], qk[16], ql[16];
   int         nchk  = 0;
   int         nfail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_q(input int i, input bit hit);
      qk[i] = 3'($urandom_range(0, 7));
      ql[i] = 3'd0;
      qa[i] = hit ? qk[i] : (qk[i] ^ 3'($urandom_range(1, 7)));
   endtask

   // Session-level reference: pass threshold 5, streak length 3, bonus caps at 3.
   function automatic exp_t model(input int nq);
      exp_t e;
      int   sc, st, bn;
      bit   lucky_spent, hit;
      sc = 0; st = 0; bn = 0; lucky_spent = 0;
      for (int q = 0; q < nq; q++) begin
         hit = 0;
         if (qa[q] == qk[q]) hit = 1;
         else if (((qa[q] ^ ql[q]) == qk[q]) && !lucky_spent) begin
            hit = 1;
            lucky_spent = 1;
         end
         if (hit) begin
            sc++;
            st++;
            if (st == 3) begin
               st = 0;
               if (bn < 3) bn++;
            end
         end else begin
            st = 0;
         end
      end
      e.score = 4'(sc);
      e.pass2 = (sc >= 5);
      e.bonus = 2'(bn);
      return e;
   endfunction

   task automatic run_session(input int nq, input bit gaps, input bit mid_start, input int rst_after);
      exp_t e;
      int   i, cyc, k;
      bit   hs;
      if (rst_after == 0) sb.push_back(model(nq));
      if (sel12) start12 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0; start12 = 1'b0;
      cyc = 1;
      chk("busy_after_start", s_busy, 1);
      chk("score_cleared", s_score, 0);
      chk("pass2_cleared", s_pass2, 0);
      chk("bonus2_cleared", s_bonus2, 0);
      i = 0;
      while (i < nq && cyc < 400) begin
         if (gaps && $urandom_range(0, 2) == 0) ans_valid = 1'b0;
         else begin
            ans_valid = 1'b1;
            ans = qa[i]; key = qk[i]; luck2 = ql[i];
         end
         if (mid_start && cyc == 5) begin
            if (sel12) start12 = 1'b1; else start = 1'b1;
         end else begin
            start = 1'b0; start12 = 1'b0;
         end
         hs = s_ready && ans_valid;
         @(negedge clk);
         cyc++;
         if (hs) begin
            i++;
            chk("ready_low_in_judge", s_ready, 0);
            if (rst_after != 0 && i == rst_after) begin
               rst = 1'b1;
               @(negedge clk);
               rst = 1'b0; ans_valid = 1'b0;
               chk("rst_busy", s_busy, 0);
               chk("rst_ready", s_ready, 0);
               chk("rst_done", s_done, 0);
               chk("rst_score", s_score, 0);
               chk("rst_pass2", s_pass2, 0);
               chk("rst_bonus2", s_bonus2, 0);
               return;
            end
         end
      end
      start = 1'b0; start12 = 1'b0; ans_valid = 1'b0;
      chk("answers_consumed", i, nq);
      k = 0;
      do begin
         @(negedge clk);
         cyc++; k++;
      end while (!s_done && k < 8);
      chk("done_seen", s_done, 1);
      if (!gaps) chk("done_latency", cyc, 2 * nq + 1);
      e = sb.pop_front();
      last_e = e;
      chk("score", s_score, e.score);
      chk("pass2", s_pass2, e.pass2);
      chk("bonus2", s_bonus2, e.bonus);
      @(negedge clk);
      chk("done_one_cycle", s_done, 0);
      chk("idle_after_done", s_busy, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start12 = 1'b0; ans_valid = 1'b0;
      ans = '0; key = '0; luck2 = '0; sel12 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_ready", rdy8, 0);
      chk("reset_busy", busy8, 0);
      chk("reset_done", done8, 0);
      chk("reset_score", score8, 0);
      chk("reset_pass2", pass8, 0);
      chk("reset_bonus2", bonus8, 0);
      chk("reset_busy12", busy12, 0);

      // All hits, valid held high.
      for (int q = 0; q < 8; q++) set_q(q, 1);
      run_session(8, 0, 0, 0);

      // H,H,M,H,H,M,H,M then the same with the last hit flipped.
      for (int q = 0; q < 8; q++) set_q(q, (q != 2) && (q != 5) && (q != 7));
      run_session(8, 0, 0, 0);
      set_q(6, 0);
      run_session(8, 0, 0, 0);

      // Lucky guess accepted once, second identical attempt is a miss.
      qa[0] = 3'd3; qk[0] = 3'd5; ql[0] = 3'd6;
      qa[1] = 3'd3; qk[1] = 3'd5; ql[1] = 3'd6;
      for (int q = 2; q < 8; q++) set_q(q, 1);
      run_session(8, 0, 0, 0);

      // Random valid gaps plus a stray start mid-session.
      for (int q = 0; q < 8; q++) set_q(q, 1);
      run_session(8, 1, 1, 0);

      // Results hold through idle cycles, even with ans_valid asserted.
      ans_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("hold_busy", s_busy, 0);
         chk("hold_score", s_score, last_e.score);
         chk("hold_pass2", s_pass2, last_e.pass2);
         chk("hold_bonus2", s_bonus2, last_e.bonus);
      end
      ans_valid = 1'b0;

      // Reset after the 4th answer, then a full mixed session.
      for (int q = 0; q < 8; q++) set_q(q, 1);
      run_session(8, 0, 0, 4);
      for (int q = 0; q < 8; q++) set_q(q, $urandom_range(0, 3) != 0);
      qa[3] = 3'd1; qk[3] = 3'd2; ql[3] = 3'd3;
      run_session(8, 1, 0, 0);

      // Twelve hits on the NUM_Q=12 instance: bonus saturates at 3.
      sel12 = 1'b1;
      for (int q = 0; q < 12; q++) set_q(q, 1);
      run_session(12, 0, 0, 0);
      chk("sat_bonus_const", s_bonus2, 3);
      sel12 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
